// File: rtl/psum_writeback_if.sv
// Handshake/bus bundle between the psum writeback engine, its controller,
// the corelet OFIFO and the psum SRAM.
interface psum_writeback_if #(
    parameter int unsigned COL         = 8,
    parameter int unsigned PSUM_BW     = 16,
    parameter int unsigned PSUM_ADDR_W = 14
);
    localparam int unsigned DW = COL * PSUM_BW;

    logic                   start;
    logic                   abort;
    logic [PSUM_ADDR_W-1:0] base_addr;
    logic [PSUM_ADDR_W-1:0] len;
    logic                   ofifo_valid;
    logic [DW-1:0]          ofifo_dout;
    logic                   ofifo_rd;
    logic                   psum_cen;
    logic                   psum_wen;
    logic [PSUM_ADDR_W-1:0] psum_addr;
    logic [DW-1:0]          psum_d;
    logic                   busy;
    logic                   done;
    logic [PSUM_ADDR_W-1:0] wr_count;

    // Controller / OFIFO / SRAM side
    modport master (
        output start, abort, base_addr, len, ofifo_valid, ofifo_dout,
        input  ofifo_rd, psum_cen, psum_wen, psum_addr, psum_d, busy, done, wr_count
    );

    // Writeback engine side
    modport slave (
        input  start, abort, base_addr, len, ofifo_valid, ofifo_dout,
        output ofifo_rd, psum_cen, psum_wen, psum_addr, psum_d, busy, done, wr_count
    );
endinterface

// File: rtl/psum_writeback.sv
// psum_writeback: drains OFIFO vectors into the psum SRAM at consecutive,
// wrapping addresses starting at base_addr. One vector per cycle while the
// OFIFO has data; each pop is written to SRAM in the following cycle.
module psum_writeback #(
    parameter int unsigned col         = 8,
    parameter int unsigned psum_bw     = 16,
    parameter int unsigned PSUM_DEPTH  = 14112,
    parameter int unsigned PSUM_ADDR_W = $clog2(PSUM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    psum_writeback_if.slave   bus
);
    localparam int unsigned DW = col * psum_bw;
    localparam int unsigned AW = PSUM_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DRAIN     = 2'd1,
        S_WAIT_LAST = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t         state_q;
    logic [AW-1:0]  len_q;
    logic [AW-1:0]  issued_q;
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  wr_count_q;
    logic           wr_pend_q;
    logic           done_q;
    logic           busy_q;
    logic [DW-1:0]  d_hold_q;

    logic           rd_d;
    logic [AW-1:0]  wptr_d;
    logic           last_rd_d;

    // Pop request: only while draining, data present, reads outstanding, not aborting
    assign rd_d = (state_q == S_DRAIN) & bus.ofifo_valid & (issued_q < len_q) & ~bus.abort;

    // Write pointer advance with wrap at the SRAM depth
    assign wptr_d = (wptr_q == AW'(PSUM_DEPTH - 1)) ? '0 : AW'(wptr_q + 1'b1);

    // This pop is the final one of the transfer
    assign last_rd_d = rd_d & (AW'(issued_q + 1'b1) == len_q);

    // Control FSM, read/write counters and the registered SRAM strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            wptr_q     <= '0;
            addr_q     <= '0;
            wr_count_q <= '0;
            wr_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            d_hold_q   <= '0;
        end else begin
            wr_pend_q <= rd_d;
            done_q    <= 1'b0;

            // OFIFO data arrives in the write cycle; keep it so psum_d holds afterwards
            if (wr_pend_q) begin
                d_hold_q <= bus.ofifo_dout;
            end

            // Each pop schedules one write at the current pointer
            if (rd_d) begin
                issued_q   <= AW'(issued_q + 1'b1);
                addr_q     <= wptr_q;
                wptr_q     <= wptr_d;
                wr_count_q <= AW'(wr_count_q + 1'b1);
            end

            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q      <= bus.len;
                        issued_q   <= '0;
                        wptr_q     <= bus.base_addr;
                        wr_count_q <= '0;
                        busy_q     <= 1'b1;
                        if (bus.len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_rd_d) begin
                        state_q <= S_WAIT_LAST;
                    end
                end
                S_WAIT_LAST: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ofifo_rd  = rd_d;
    assign bus.psum_cen  = ~wr_pend_q;
    assign bus.psum_wen  = ~wr_pend_q;
    assign bus.psum_addr = addr_q;
    // Data is only valid from the OFIFO in the write cycle; otherwise hold the last word
    assign bus.psum_d    = wr_pend_q ? bus.ofifo_dout : d_hold_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: OFIFO model plus address/data scoreboard, with
// one task per scenario checking pop, write, done and busy behaviour.
module tb_psum_writeback;
    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 14112;
    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = COL * BW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic reset;

    psum_writeback_if #(.COL(COL), .PSUM_BW(BW), .PSUM_ADDR_W(AW)) bus ();

    psum_writeback #(
        .col        (COL),
        .psum_bw    (BW),
        .PSUM_DEPTH (DEPTH),
        .PSUM_ADDR_W(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int            total;
    int            bad;
    int            tag;
    int            pop_idx;
    int            writes_seen;
    logic [AW-1:0] exp_base;
    exp_t          q[$];
    logic          pend;
    logic [DW-1:0] pend_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input int k);
        logic [31:0] w;
        w = 32'(tag * 1000 + k) * 32'h9E37_79B1;
        return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1};
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int k);
        int a;
        a = (int'(exp_base) + k) % int'(DEPTH);
        return AW'(a);
    endfunction

    // Scoreboard: record each pop, compare each SRAM write against the oldest pop
    always @(negedge clk) begin
        exp_t e;
        exp_t ne;
        if (reset) begin
            if (!bus.psum_cen) begin
                writes_seen++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_write: got write at addr=%0d, want no write", bus.psum_addr);
                end else begin
                    e = q.pop_front();
                    if (bus.psum_addr !== e.addr || bus.psum_d !== e.data || bus.psum_wen !== 1'b0) begin
                        bad++;
                        $display("FAIL write: got addr=%0d wen=%b d=%h, want addr=%0d wen=0 d=%h",
                                 bus.psum_addr, bus.psum_wen, bus.psum_d, e.addr, e.data);
                    end
                end
            end
            if (bus.ofifo_rd) begin
                total++;
                if (bus.ofifo_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rd_without_valid: got ofifo_rd=1 with valid=%b, want valid=1", bus.ofifo_valid);
                end
                ne.addr = exp_addr(pop_idx);
                ne.data = data_of(pop_idx);
                q.push_back(ne);
                pend_data = ne.data;
                pend      = 1'b1;
                pop_idx++;
            end
        end
    end

    // OFIFO model: popped word appears the cycle after ofifo_rd, junk otherwise
    always @(posedge clk) begin
        #1;
        if (pend) begin
            bus.ofifo_dout = pend_data;
            pend = 1'b0;
        end else begin
            bus.ofifo_dout = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    task automatic start_op(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(posedge clk);
        #1;
        tag++;
        pop_idx     = 0;
        writes_seen = 0;
        q.delete();
        exp_base      = b;
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.len       = l;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Runs ncyc cycles from start+1, driving valid/abort and recording what the DUT did
    task automatic observe(input int ncyc, input logic [31:0] vpat, input int abort_cyc,
                           output int rd_cnt, output int first_rd, output int done_cyc,
                           output int done_cnt, output int busy_cnt);
        rd_cnt = 0; first_rd = 0; done_cyc = 0; done_cnt = 0; busy_cnt = 0;
        for (int i = 1; i <= ncyc; i++) begin
            bus.ofifo_valid = (i <= 32) ? vpat[i-1] : 1'b0;
            bus.abort       = (i == abort_cyc);
            @(negedge clk);
            if (bus.ofifo_rd) begin
                rd_cnt++;
                if (first_rd == 0) first_rd = i;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = i;
            end
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        bus.ofifo_valid = 1'b1;
        #3;
        total++; if (bus.ofifo_rd !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", bus.ofifo_rd); end
        total++; if (bus.psum_cen !== 1'b1 || bus.psum_wen !== 1'b1) begin bad++; $display("FAIL reset_cen_wen: got %b%b want 11", bus.psum_cen, bus.psum_wen); end
        total++; if (bus.psum_addr !== '0 || bus.psum_d !== '0) begin bad++; $display("FAIL reset_addr_d: got addr=%0d d=%h want 0", bus.psum_addr, bus.psum_d); end
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_count !== '0) begin bad++; $display("FAIL reset_status: got busy=%b done=%b wr_count=%0d want 0", bus.busy, bus.done, bus.wr_count); end
        @(negedge clk);
        #1 reset = 1'b1;
        bus.ofifo_valid = 1'b0;
    endtask

    task automatic test_basic();
        int rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt;
        start_op(AW'(100), AW'(4));
        observe(12, '1, 0, rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt);
        total++; if (rd_cnt !== 4 || first_rd !== 1) begin bad++; $display("FAIL basic_rd: got cnt=%0d first=%0d want 4/1", rd_cnt, first_rd); end
        total++; if (done_cyc !== 6 || done_cnt !== 1) begin bad++; $display("FAIL basic_done: got cyc=%0d cnt=%0d want 6/1", done_cyc, done_cnt); end
        total++; if (busy_cnt !== 6) begin bad++; $display("FAIL basic_busy: got %0d want 6", busy_cnt); end
        total++; if (bus.wr_count !== AW'(4) || writes_seen !== 4 || q.size() !== 0) begin bad++; $display("FAIL basic_count: got wr_count=%0d writes=%0d left=%0d want 4/4/0", bus.wr_count, writes_seen, q.size()); end
    endtask

    task automatic test_valid_gaps();
        int rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt;
        start_op(AW'(0), AW'(3));
        observe(12, 32'b10101, 0, rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt);
        total++; if (rd_cnt !== 3) begin bad++; $display("FAIL gaps_rd: got %0d want 3", rd_cnt); end
        total++; if (done_cyc !== 7 || done_cnt !== 1) begin bad++; $display("FAIL gaps_done: got cyc=%0d cnt=%0d want 7/1", done_cyc, done_cnt); end
        total++; if (writes_seen !== 3 || q.size() !== 0 || bus.wr_count !== AW'(3)) begin bad++; $display("FAIL gaps_count: got writes=%0d left=%0d wr_count=%0d want 3/0/3", writes_seen, q.size(), bus.wr_count); end
    endtask

    task automatic test_wrap();
        int rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt;
        logic [DW-1:0] last_d;
        start_op(AW'(DEPTH - 2), AW'(4));
        last_d = data_of(3);
        observe(12, '1, 0, rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt);
        total++; if (bus.wr_count !== AW'(4) || writes_seen !== 4 || q.size() !== 0) begin bad++; $display("FAIL wrap_count: got wr_count=%0d writes=%0d left=%0d want 4/4/0", bus.wr_count, writes_seen, q.size()); end
        total++; if (done_cyc !== 6) begin bad++; $display("FAIL wrap_done: got %0d want 6", done_cyc); end
        total++; if (bus.psum_addr !== AW'(1) || bus.psum_d !== last_d || bus.psum_cen !== 1'b1) begin bad++; $display("FAIL wrap_hold: got addr=%0d cen=%b d=%h want 1/1/%h", bus.psum_addr, bus.psum_cen, bus.psum_d, last_d); end
    endtask

    task automatic test_len_zero();
        int rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt;
        start_op(AW'(7), AW'(0));
        observe(8, '1, 0, rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt);
        total++; if (rd_cnt !== 0 || writes_seen !== 0) begin bad++; $display("FAIL len0_activity: got rd=%0d writes=%0d want 0/0", rd_cnt, writes_seen); end
        total++; if (done_cyc !== 1 || done_cnt !== 1) begin bad++; $display("FAIL len0_done: got cyc=%0d cnt=%0d want 1/1", done_cyc, done_cnt); end
        total++; if (busy_cnt !== 1 || bus.wr_count !== '0) begin bad++; $display("FAIL len0_busy: got busy=%0d wr_count=%0d want 1/0", busy_cnt, bus.wr_count); end
    endtask

    task automatic test_abort();
        int rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt;
        start_op(AW'(500), AW'(8));
        observe(12, '1, 3, rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt);
        total++; if (rd_cnt !== 2 || writes_seen !== 2 || q.size() !== 0) begin bad++; $display("FAIL abort_writes: got rd=%0d writes=%0d left=%0d want 2/2/0", rd_cnt, writes_seen, q.size()); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        total++; if (busy_cnt !== 3 || bus.busy !== 1'b0 || bus.wr_count !== AW'(2)) begin bad++; $display("FAIL abort_idle: got busy_cnt=%0d busy=%b wr_count=%0d want 3/0/2", busy_cnt, bus.busy, bus.wr_count); end
        start_op(AW'(200), AW'(1));
        observe(8, '1, 0, rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt);
        total++; if (rd_cnt !== 1 || done_cyc !== 3 || writes_seen !== 1 || q.size() !== 0) begin bad++; $display("FAIL abort_restart: got rd=%0d done=%0d writes=%0d left=%0d want 1/3/1/0", rd_cnt, done_cyc, writes_seen, q.size()); end
    endtask

    task automatic test_reset_mid();
        int rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt;
        start_op(AW'(300), AW'(6));
        observe(4, '1, 0, rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt);
        total++; if (rd_cnt !== 4 || writes_seen !== 3) begin bad++; $display("FAIL midrst_pre: got rd=%0d writes=%0d want 4/3", rd_cnt, writes_seen); end
        #1 reset = 1'b0;
        #1;
        total++; if (bus.ofifo_rd !== 1'b0 || bus.psum_cen !== 1'b1 || bus.psum_wen !== 1'b1) begin bad++; $display("FAIL midrst_strobes: got rd=%b cen=%b wen=%b want 0/1/1", bus.ofifo_rd, bus.psum_cen, bus.psum_wen); end
        total++; if (bus.psum_addr !== '0 || bus.psum_d !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_count !== '0) begin bad++; $display("FAIL midrst_values: got addr=%0d busy=%b done=%b wr_count=%0d want all 0", bus.psum_addr, bus.busy, bus.done, bus.wr_count); end
        q.delete();
        pend = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        start_op(AW'(50), AW'(2));
        observe(10, '1, 0, rd_cnt, first_rd, done_cyc, done_cnt, busy_cnt);
        total++; if (rd_cnt !== 2 || done_cyc !== 4 || done_cnt !== 1) begin bad++; $display("FAIL midrst_fresh: got rd=%0d done_cyc=%0d done_cnt=%0d want 2/4/1", rd_cnt, done_cyc, done_cnt); end
        total++; if (writes_seen !== 2 || q.size() !== 0 || bus.wr_count !== AW'(2)) begin bad++; $display("FAIL midrst_count: got writes=%0d left=%0d wr_count=%0d want 2/0/2", writes_seen, q.size(), bus.wr_count); end
    endtask

    initial begin
        total = 0; bad = 0; tag = 0; pop_idx = 0; writes_seen = 0;
        exp_base = '0; pend = 1'b0; pend_data = '0;
        reset = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.len = '0;
        bus.ofifo_valid = 1'b0; bus.ofifo_dout = '0;
        test_reset();
        test_basic();
        test_valid_gaps();
        test_wrap();
        test_len_zero();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
